// File: rtl/timer_run_ctrl.sv
// Run/configuration sequencer for the timer: applies software config at safe points and runs the debug halt handshake.
// Optional upd_done/upd_forced pulse outputs are enabled by defining TIMER_UPD_DONE_EN.
module timer_run_ctrl #(
  parameter int WAIT_MAX = 256,
  parameter int TW       = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cfg_wr,
  input  logic       i_sw_timer_en,
  input  logic       i_sw_div_en,
  input  logic [3:0] i_sw_div_val,
  input  logic       i_dbg_mode,
  input  logic       i_halt_req,
  input  logic       i_cnt_en,
  output logic       o_timer_en,
  output logic       o_div_en,
  output logic [3:0] o_div_val,
  output logic       o_cfg_busy,
  output logic       o_halt_ack,
  output logic [1:0] o_state
`ifdef TIMER_UPD_DONE_EN
  ,
  output logic       o_upd_done,
  output logic       o_upd_forced
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_UPD_WAIT = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_MAX - 1);
  localparam logic [TW-1:0] WAIT_SAT  = TW'(WAIT_MAX);

  state_t        r_state;
  state_t        w_next;
  logic          r_timer_en;
  logic          r_div_en;
  logic [3:0]    r_div_val;
  logic          r_busy;
  logic          r_halt_ack;
  logic          r_pend_te;
  logic          r_pend_de;
  logic [3:0]    r_pend_dv;
  logic [TW-1:0] r_wait_cnt;
  logic          w_hc;
  logic          w_div_diff;
  logic          w_apply;

  assign w_hc       = i_dbg_mode & i_halt_req;
  assign w_div_diff = (r_pend_de != r_div_en) || (r_pend_dv != r_div_val);

  always_comb begin
    w_next  = r_state;
    w_apply = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_busy) begin
          w_apply = 1'b1;
          w_next  = r_pend_te ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (w_hc) begin
          w_next = S_HALTED;
        end else if (r_busy) begin
          if (!r_pend_te) begin
            w_apply = 1'b1;
            w_next  = S_IDLE;
          end else if (w_div_diff) begin
            w_next = S_UPD_WAIT;
          end else begin
            w_apply = 1'b1;
          end
        end
      end
      S_UPD_WAIT: begin
        // A disable rewritten while waiting must not wait for a tick boundary.
        if (w_hc) begin
          w_next = S_HALTED;
        end else if (!r_pend_te) begin
          w_apply = 1'b1;
          w_next  = S_IDLE;
        end else if (i_cnt_en || (r_wait_cnt >= WAIT_LAST)) begin
          w_apply = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_HALTED: begin
        if (!w_hc) begin
          w_next = (r_busy && w_div_diff) ? S_UPD_WAIT : S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_timer_en <= 1'b0;
      r_div_en   <= 1'b0;
      r_div_val  <= 4'd0;
      r_busy     <= 1'b0;
      r_halt_ack <= 1'b0;
      r_pend_te  <= 1'b0;
      r_pend_de  <= 1'b0;
      r_pend_dv  <= 4'd0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_halt_ack <= (w_next == S_HALTED);
      if (w_apply) begin
        r_timer_en <= r_pend_te;
        r_div_en   <= r_pend_de;
        r_div_val  <= r_pend_dv;
      end
      if (i_cfg_wr) begin
        r_pend_te <= i_sw_timer_en;
        r_pend_de <= i_sw_div_en;
        r_pend_dv <= i_sw_div_val;
        r_busy    <= 1'b1;
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end
      // The wait count survives a halt so a resumed update still times out on schedule.
      if (r_state == S_UPD_WAIT) begin
        if (w_apply) begin
          r_wait_cnt <= '0;
        end else if (r_wait_cnt < WAIT_SAT) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end else if (r_state != S_HALTED) begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_timer_en = r_timer_en;
  assign o_div_en   = r_div_en;
  assign o_div_val  = r_div_val;
  assign o_cfg_busy = r_busy;
  assign o_halt_ack = r_halt_ack;
  assign o_state    = r_state;

`ifdef TIMER_UPD_DONE_EN
  logic r_upd_done;
  logic r_upd_forced;
  logic w_forced;

  // Leaving UPD_WAIT for RUN without a tick can only be the timeout.
  assign w_forced = (r_state == S_UPD_WAIT) && (w_next == S_RUN) && !i_cnt_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_upd_done   <= 1'b0;
      r_upd_forced <= 1'b0;
    end else begin
      r_upd_done   <= w_apply;
      r_upd_forced <= w_forced;
    end
  end

  assign o_upd_done   = r_upd_done;
  assign o_upd_forced = r_upd_forced;
`endif

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Randomized self-checking bench for timer_run_ctrl against a behavioural reference model.
// Directed scenarios first, then a long random run with occasional resets.
module tb_timer_run_ctrl;

  localparam int WAIT_MAX = 256;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_WAIT = 2;
  localparam int ST_HALT = 3;

  logic       clk;
  logic       rst;
  logic       cfgWr;
  logic       swTimerEn;
  logic       swDivEn;
  logic [3:0] swDivVal;
  logic       dbgMode;
  logic       haltReq;
  logic       cntEn;
  logic       timerEn;
  logic       divEn;
  logic [3:0] divVal;
  logic       cfgBusy;
  logic       haltAck;
  logic [1:0] state;
`ifdef TIMER_UPD_DONE_EN
  logic       updDone;
  logic       updForced;
`endif

  int nChecks = 0;
  int nErrors = 0;

  int mState, mTe, mDe, mDv, mBusy, mAck, mPte, mPde, mPdv, mWaited, mDone, mForced;

  timer_run_ctrl #(.WAIT_MAX(WAIT_MAX), .TW(9)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cfg_wr     (cfgWr),
    .i_sw_timer_en(swTimerEn),
    .i_sw_div_en  (swDivEn),
    .i_sw_div_val (swDivVal),
    .i_dbg_mode   (dbgMode),
    .i_halt_req   (haltReq),
    .i_cnt_en     (cntEn),
    .o_timer_en   (timerEn),
    .o_div_en     (divEn),
    .o_div_val    (divVal),
    .o_cfg_busy   (cfgBusy),
    .o_halt_ack   (haltAck),
    .o_state      (state)
`ifdef TIMER_UPD_DONE_EN
    ,
    .o_upd_done   (updDone),
    .o_upd_forced (updForced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState = ST_IDLE; mTe = 0; mDe = 0; mDv = 0; mBusy = 0; mAck = 0;
    mPte = 0; mPde = 0; mPdv = 0; mWaited = 0; mDone = 0; mForced = 0;
  endtask

  // One clock of the reference: decide from the old state and current inputs, then commit.
  task automatic modelStep();
    int  ns;
    bit  apply, forced, hc, diff;
    hc     = dbgMode && haltReq;
    diff   = (mPde != mDe) || (mPdv != mDv);
    ns     = mState;
    apply  = 0;
    forced = 0;
    if (mState == ST_IDLE) begin
      if (mBusy != 0) begin apply = 1; ns = (mPte != 0) ? ST_RUN : ST_IDLE; end
    end else if (mState == ST_RUN) begin
      if (hc) ns = ST_HALT;
      else if (mBusy != 0 && mPte == 0) begin apply = 1; ns = ST_IDLE; end
      else if (mBusy != 0 && diff) ns = ST_WAIT;
      else if (mBusy != 0) apply = 1;
    end else if (mState == ST_WAIT) begin
      if (hc) ns = ST_HALT;
      else if (mPte == 0) begin apply = 1; ns = ST_IDLE; end
      else if (cntEn) begin apply = 1; ns = ST_RUN; end
      else if (mWaited + 1 >= WAIT_MAX) begin apply = 1; forced = 1; ns = ST_RUN; end
    end else begin
      if (!hc) ns = (mBusy != 0 && diff) ? ST_WAIT : ST_RUN;
    end
    if (mState == ST_WAIT) mWaited = apply ? 0 : ((mWaited < WAIT_MAX) ? mWaited + 1 : mWaited);
    else if (mState != ST_HALT) mWaited = 0;
    if (apply) begin mTe = mPte; mDe = mPde; mDv = mPdv; end
    if (cfgWr) begin
      mBusy = 1; mPte = swTimerEn; mPde = swDivEn; mPdv = swDivVal;
    end else if (apply) begin
      mBusy = 0;
    end
    mAck    = (ns == ST_HALT) ? 1 : 0;
    mDone   = apply;
    mForced = forced;
    mState  = ns;
  endtask

  task automatic compareAll();
    checkOutput("timer_en", timerEn, mTe);
    checkOutput("div_en", divEn, mDe);
    checkOutput("div_val", divVal, mDv);
    checkOutput("cfg_busy", cfgBusy, mBusy);
    checkOutput("halt_ack", haltAck, mAck);
    checkOutput("state", state, mState);
`ifdef TIMER_UPD_DONE_EN
    checkOutput("upd_done", updDone, mDone);
    checkOutput("upd_forced", updForced, mForced);
`endif
  endtask

  task automatic applyStimulus(input bit wr, input bit te, input bit de, input int dv,
                               input bit dbg, input bit hreq, input bit cnt);
    cfgWr     = wr;
    swTimerEn = te;
    swDivEn   = de;
    swDivVal  = 4'(dv);
    dbgMode   = dbg;
    haltReq   = hreq;
    cntEn     = cnt;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    compareAll();
    checkOutput("reset_state", state, 0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int ackCount;
    int haltLeft;
    rst = 1'b1;
    cfgWr = 0; swTimerEn = 0; swDivEn = 0; swDivVal = 0;
    dbgMode = 0; haltReq = 0; cntEn = 0;
    modelReset();
    #1;
    compareAll();
    #12;
    rst = 1'b0;

    $display("[TB] enable from IDLE");
    applyStimulus(1, 1, 1, 3, 0, 0, 0);
    checkOutput("tp1_busy", cfgBusy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp1_timer_en", timerEn, 1);
    checkOutput("tp1_div_val", divVal, 3);
    checkOutput("tp1_state", state, ST_RUN);
    checkOutput("tp1_busy_clr", cfgBusy, 0);

    $display("[TB] divider change at tick");
    applyStimulus(1, 1, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp2_state_wait", state, ST_WAIT);
    idle(8);
    checkOutput("tp2_div_hold", divVal, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("tp2_div_new", divVal, 5);
    checkOutput("tp2_state_run", state, ST_RUN);

    $display("[TB] forced apply on timeout");
    applyStimulus(1, 1, 1, 7, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (state == 2'(ST_WAIT) && k < 400) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      k++;
    end
    checkOutput("tp3_wait_cycles", k, WAIT_MAX);
    checkOutput("tp3_div_val", divVal, 7);
`ifdef TIMER_UPD_DONE_EN
    checkOutput("tp3_upd_forced", updForced, 1);
`endif

    $display("[TB] debug halt with write during halt");
    ackCount = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 1, 1, 1, 2, 1, 1, 0);
      if (haltAck) ackCount++;
    end
    checkOutput("tp4_ack_cycles", ackCount, 5);
    checkOutput("tp4_frozen", divVal, 7);
    checkOutput("tp4_busy", cfgBusy, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("tp4_release_ack", haltAck, 0);
    checkOutput("tp4_release_state", state, ST_WAIT);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("tp4_applied", divVal, 2);

    $display("[TB] halt and tick together");
    applyStimulus(1, 1, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkOutput("tp5_state", state, ST_HALT);
    checkOutput("tp5_div_val", divVal, 2);
    checkOutput("tp5_busy", cfgBusy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("tp5_applied", divVal, 4);

    $display("[TB] disable then reset mid-wait");
    applyStimulus(1, 0, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp6_timer_en", timerEn, 0);
    checkOutput("tp6_state", state, ST_IDLE);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 6, 0, 0, 0);
    idle(4);
    checkOutput("tp6_pre_reset_state", state, ST_WAIT);
    doReset();
    checkOutput("tp6_reset_timer_en", timerEn, 0);
    checkOutput("tp6_reset_div_val", divVal, 0);

    $display("[TB] random phase");
    haltLeft = 0;
    for (int c = 0; c < 4000; c++) begin
      bit wr, te, de, dbg, hreq, cnt;
      int dv;
      wr = ($urandom % 8) == 0;
      te = ($urandom % 6) != 0;
      de = ($urandom % 4) != 0;
      dv = ($urandom % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      if (haltLeft == 0 && ($urandom % 50) == 0) haltLeft = $urandom_range(1, 8);
      hreq = haltLeft > 0;
      if (haltLeft > 0) haltLeft--;
      dbg = ($urandom % 8) != 0;
      cnt = (((c / 500) % 2) == 0) && (($urandom % 20) == 0);
      if (($urandom % 1000) == 0) doReset();
      applyStimulus(wr, te, de, dv, dbg, hreq, cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
- Run/configuration sequencer in front of the timer counter-control stage.
- Owns the timer_en, div_en and div_val signals that drive the prescaler/counter control.
- Applies software configuration writes only at safe points: immediately when stopped, at a prescaler tick boundary when running.
- Runs the debug halt request/acknowledge handshake so the counter never sees a mid-period prescaler change or a glitchy halt.

Parameters:
- WAIT_MAX, 256: maximum cycles spent in UPD_WAIT before a pending divider update is forced. Matches the largest prescaler period.
- TW, 9: width of the wait/timeout counter; must satisfy 2^TW > WAIT_MAX.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- cfg_wr  input  1  one-cycle pulse; capture sw_* into pending registers
- sw_timer_en  input  1  requested timer enable
- sw_div_en  input  1  requested prescaler enable
- sw_div_val  input  4  requested prescaler select
- dbg_mode  input  1  debug mode active
- halt_req  input  1  debugger halt request
- cnt_en  input  1  counter tick from counter-control stage (prescaler boundary)
- timer_en  output  1  applied timer enable
- div_en  output  1  applied prescaler enable
- div_val  output  4  applied prescaler select
- cfg_busy  output  1  pending configuration not yet applied
- halt_ack  output  1  timer halted, acknowledge to debugger
- state  output  2  FSM state: IDLE=0, RUN=1, UPD_WAIT=2, HALTED=3

Behaviour:
- Reset values: state=IDLE; timer_en=0, div_en=0, div_val=0; cfg_busy=0; halt_ack=0; pending regs=0; wait counter=0. All outputs are registered.
- halt condition: hc = dbg_mode & halt_req.
- cfg_wr capture:
  - Captures sw_* into pending and sets cfg_busy on the next edge.
  - A cfg_wr while cfg_busy=1 overwrites pending (last write wins) and does not restart the wait counter.
  - cfg_wr in the same cycle as an apply: the new value is captured and cfg_busy stays 1.
- "Apply": copy pending to timer_en/div_en/div_val and clear cfg_busy, on one edge.
- IDLE (timer_en=0):
  - cfg_busy=1: apply next edge. Go to RUN if the applied timer_en=1, else stay in IDLE.
  - hc is ignored; halt_ack stays 0.
- RUN, priority high to low:
  - hc=1: go to HALTED.
  - cfg_busy=1 and pending timer_en=0: apply next edge, go to IDLE. Disable is immediate.
  - cfg_busy=1 and pending div_en/div_val differ from applied: go to UPD_WAIT, clear the wait counter.
  - cfg_busy=1 and the pending values are identical: apply next edge, stay in RUN.
- UPD_WAIT:
  - Wait counter increments every cycle.
  - hc=1: go to HALTED. Pending and the wait counter are retained.
  - cnt_en=1: apply on the same edge, go to RUN.
  - Wait counter reaches WAIT_MAX-1 without cnt_en: apply on that edge (forced), go to RUN.
  - Pending timer_en=0 (rewritten while waiting): apply immediately, go to IDLE.
- HALTED:
  - halt_ack=1 from the first cycle in HALTED, i.e. one cycle after hc is sampled in RUN/UPD_WAIT.
  - Applied outputs are frozen.
  - cfg_wr is captured only; it is never applied while halted.
  - hc=0: go to UPD_WAIT if cfg_busy and divider values differ, else RUN. Any other pending change is handled in RUN next cycle.
  - halt_ack drops on the exit edge.
- Simultaneous hc and cnt_en in UPD_WAIT: halt wins and the update stays pending.
- Reset mid-operation: all state returns to reset values immediately; pending is discarded.
- div_val is passed through unchanged; values above 7 select /256 downstream.

Optional Feature:
- TIMER_UPD_DONE_EN defined:
  - Adds output upd_done (1 bit, reset 0).
  - Registered one-cycle pulse on every apply.
  - Adds output upd_forced (1 bit, reset 0), pulsing with upd_done when the apply was caused by the WAIT_MAX timeout.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then cfg_wr with timer_en=1, div_en=1, div_val=3 in IDLE -> next edge timer_en=1, div_val=3, state=RUN, cfg_busy=0.
- RUN, cfg_wr div_val=5, cnt_en pulsed 10 cycles later -> state=UPD_WAIT, div_val stays 3 until the cnt_en edge, then 5, back to RUN.
- RUN, cfg_wr div_val=7, cnt_en held 0 -> forced apply after 256 cycles in UPD_WAIT; upd_forced pulses when TIMER_UPD_DONE_EN is defined.
- RUN, dbg_mode=1 and halt_req=1 for 5 cycles with a cfg_wr during the halt -> halt_ack=1 for 5 cycles, outputs frozen, cfg_busy=1. On release goes to UPD_WAIT, then applies at the next cnt_en.
- UPD_WAIT with hc and cnt_en in the same cycle -> HALTED, div_val unchanged, cfg_busy=1.
- RUN, cfg_wr timer_en=0 -> next edge timer_en=0, state=IDLE. Then assert rst mid-UPD_WAIT -> all outputs 0 immediately.
